// File: rtl/mreq_pkg.sv
// -----------------------------------------------------------------------------
// mreq_pkg
//   Shared definitions for the memory-request (MREQ) bus and its arbiter.
//   - Field widths of an MREQ transaction (word size, word count, address).
//   - Word-size encodings (byte / half / word).
//   - Arbiter state encoding.
//   - Packed bundle of the per-transaction fields, used to mux one requester
//     onto the execution bus.
// -----------------------------------------------------------------------------
package mreq_pkg;

    localparam int MREQ_WSIZE_W  = 2;
    localparam int MREQ_WCOUNT_W = 8;
    localparam int MREQ_ADDR_W   = 32;

    typedef enum logic [MREQ_WSIZE_W-1:0] {
        MREQ_WSIZE_BYTE = 2'd0,
        MREQ_WSIZE_HALF = 2'd1,
        MREQ_WSIZE_WORD = 2'd2
    } mreq_wsize_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Everything that travels with one MREQ besides the handshake.
    typedef struct packed {
        logic                     wr;
        logic [MREQ_WSIZE_W-1:0]  wsize;
        logic                     aincr;
        logic [MREQ_WCOUNT_W-1:0] wcount;
        logic [MREQ_ADDR_W-1:0]   addr;
    } mreq_fields_t;

endpackage : mreq_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority picker. Starting at i_start and walking
//   upward with wrap-around, the first asserted request bit wins.
//   With i_start tied to 0 it degenerates to fixed lowest-index priority.
//
// Ports
//   i_req     N_REQ  request vector
//   i_start   GW     index searched first
//   o_onehot  N_REQ  one-hot winner (all zero when no request)
//   o_idx     GW     winner index (0 when no request)
//   o_any     1      at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int N_REQ = 2,
    localparam int GW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [GW-1:0]    i_start,
    output logic [N_REQ-1:0] o_onehot,
    output logic [GW-1:0]    o_idx,
    output logic             o_any
);

    // Explicit wrap so non-power-of-two N_REQ never walks past the last index.
    localparam logic [GW-1:0] LAST = GW'(N_REQ - 1);

    logic [GW-1:0] pos;
    logic          found;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise paths that skip the write would infer a latch.
        o_onehot = '0;
        o_idx    = '0;
        found    = 1'b0;
        pos      = i_start;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && i_req[pos]) begin
                found = 1'b1;
                o_idx = pos;
            end
            pos = (pos == LAST) ? '0 : pos + GW'(1);
        end
        o_onehot[o_idx] = found;
        o_any           = found;
    end

endmodule : rr_pick

// File: rtl/mreq_arb.sv
// -----------------------------------------------------------------------------
// mreq_arb
//   Arbitrates N_REQ MREQ sources onto the single execution MREQ bus. A grant
//   is taken in IDLE, held through BUSY until the execution side completes
//   (valid & ready) or the granted requester withdraws (protocol error), and
//   is exported so upstream byte-stream muxes can steer with it. Exactly one
//   IDLE bubble cycle separates consecutive grants.
//
//   Build option MREQ_ARB_FIXED_PRIO_EN: when defined, lowest index always
//   wins and no round-robin pointer is built; otherwise round-robin starting
//   after the most recently released requester.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req_valid/o_req_ready   per-requester handshake (ready = completion)
//   i_req_wr/wsize/aincr/wcount/addr  per-requester fields, packed k-major
//   o_mreq_valid/i_mreq_ready execution-side handshake
//   o_mreq_*                  fields of the granted requester
//   o_grant, o_grant_idx      one-hot grant (0 when idle) / held index
//   o_busy                    grant held
//   o_err_proto               pulse: granted valid dropped without ready
// -----------------------------------------------------------------------------
module mreq_arb
    import mreq_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int GW    = $clog2(N_REQ)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [N_REQ-1:0]                 i_req_valid,
    output logic [N_REQ-1:0]                 o_req_ready,
    input  logic [N_REQ-1:0]                 i_req_wr,
    input  logic [N_REQ*MREQ_WSIZE_W-1:0]    i_req_wsize,
    input  logic [N_REQ-1:0]                 i_req_aincr,
    input  logic [N_REQ*MREQ_WCOUNT_W-1:0]   i_req_wcount,
    input  logic [N_REQ*MREQ_ADDR_W-1:0]     i_req_addr,
    output logic                             o_mreq_valid,
    input  logic                             i_mreq_ready,
    output logic                             o_mreq_wr,
    output logic [MREQ_WSIZE_W-1:0]          o_mreq_wsize,
    output logic                             o_mreq_aincr,
    output logic [MREQ_WCOUNT_W-1:0]         o_mreq_wcount,
    output logic [MREQ_ADDR_W-1:0]           o_mreq_addr,
    output logic [N_REQ-1:0]                 o_grant,
    output logic [GW-1:0]                    o_grant_idx,
    output logic                             o_busy,
    output logic                             o_err_proto
);

    arb_state_e       state, state_nxt;
    logic [GW-1:0]    grant_idx, grant_idx_nxt;
    logic [N_REQ-1:0] grant_oh, grant_oh_nxt;

    logic [GW-1:0]    pick_start;
    logic [GW-1:0]    pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             pick_any;

    logic             busy;
    logic             sel_valid;
    logic             handshake;
    logic             abort;
    logic             release_grant;
    mreq_fields_t     sel;

    // -------------------------------------------------------------------------
    // Winner selection
    // -------------------------------------------------------------------------
`ifdef MREQ_ARB_FIXED_PRIO_EN
    assign pick_start = '0;
`else
    localparam logic [GW-1:0] LAST = GW'(N_REQ - 1);

    // Points one past the last released requester so it goes to the back.
    logic [GW-1:0] rr_ptr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else if (release_grant) begin
            rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + GW'(1);
        end
    end

    assign pick_start = rr_ptr;
`endif

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req    (i_req_valid),
        .i_start  (pick_start),
        .o_onehot (pick_onehot),
        .o_idx    (pick_idx),
        .o_any    (pick_any)
    );

    // -------------------------------------------------------------------------
    // Granted-requester view
    // -------------------------------------------------------------------------
    assign busy      = (state == ARB_BUSY);
    assign sel_valid = i_req_valid[grant_idx];
    assign handshake = busy && sel_valid && i_mreq_ready;
    // Granted requester withdrew before completion: release and flag it.
    assign abort         = busy && !sel_valid;
    assign release_grant = handshake || abort;

    always_comb begin
        sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == GW'(k)) begin
                sel.wr     = i_req_wr[k];
                sel.wsize  = i_req_wsize[k*MREQ_WSIZE_W +: MREQ_WSIZE_W];
                sel.aincr  = i_req_aincr[k];
                sel.wcount = i_req_wcount[k*MREQ_WCOUNT_W +: MREQ_WCOUNT_W];
                sel.addr   = i_req_addr[k*MREQ_ADDR_W +: MREQ_ADDR_W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            state     <= ARB_IDLE;
            grant_idx <= '0;
            grant_oh  <= '0;
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_idx_nxt;
            grant_oh  <= grant_oh_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_idx_nxt = grant_idx;
        grant_oh_nxt  = grant_oh;
        unique case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nxt     = ARB_BUSY;
                    grant_idx_nxt = pick_idx;
                    grant_oh_nxt  = pick_onehot;
                end
            end
            ARB_BUSY: begin
                // Index is kept after release so steering stays stable.
                if (release_grant) begin
                    state_nxt    = ARB_IDLE;
                    grant_oh_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ARB_IDLE;
                grant_oh_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_busy        = busy;
    assign o_grant       = grant_oh;
    assign o_grant_idx   = grant_idx;
    assign o_mreq_valid  = busy && sel_valid;
    // Completion is passed straight back to the granted requester only.
    assign o_req_ready   = handshake ? grant_oh : '0;
    assign o_err_proto   = abort;

    assign o_mreq_wr     = sel.wr;
    assign o_mreq_wsize  = sel.wsize;
    assign o_mreq_aincr  = sel.aincr;
    assign o_mreq_wcount = sel.wcount;
    assign o_mreq_addr   = sel.addr;

endmodule : mreq_arb

// File: tb/tb_mreq_arb.sv
// -----------------------------------------------------------------------------
// tb_mreq_arb
//   Three-requester bench (exercises the non-power-of-two pointer wrap).
//   A transaction-level model predicts each grant and queues the expected
//   transaction; a monitor pops and compares on every completion pulse.
// -----------------------------------------------------------------------------
module tb_mreq_arb;

    localparam int NR = 3;
    localparam int GW = $clog2(NR);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_wr = '0;
    logic [2*NR-1:0]   req_wsize = '0;
    logic [NR-1:0]     req_aincr = '0;
    logic [8*NR-1:0]   req_wcount = '0;
    logic [32*NR-1:0]  req_addr = '0;
    logic              mreq_ready = 1'b0;

    logic [NR-1:0]     req_ready;
    logic              mreq_valid;
    logic              mreq_wr;
    logic [1:0]        mreq_wsize;
    logic              mreq_aincr;
    logic [7:0]        mreq_wcount;
    logic [31:0]       mreq_addr;
    logic [NR-1:0]     grant;
    logic [GW-1:0]     grant_idx;
    logic              busy;
    logic              err_proto;

    mreq_arb #(.N_REQ(NR)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_wr      (req_wr),
        .i_req_wsize   (req_wsize),
        .i_req_aincr   (req_aincr),
        .i_req_wcount  (req_wcount),
        .i_req_addr    (req_addr),
        .o_mreq_valid  (mreq_valid),
        .i_mreq_ready  (mreq_ready),
        .o_mreq_wr     (mreq_wr),
        .o_mreq_wsize  (mreq_wsize),
        .o_mreq_aincr  (mreq_aincr),
        .o_mreq_wcount (mreq_wcount),
        .o_mreq_addr   (mreq_addr),
        .o_grant       (grant),
        .o_grant_idx   (grant_idx),
        .o_busy        (busy),
        .o_err_proto   (err_proto)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    int exp_err  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a set of pending requests, a "currently serving" slot
    // and a round-robin start index. Expected transactions are queued at grant.
    // ------------------------------------------------------------------------
    typedef struct {
        int          idx;
        logic        wr;
        logic [1:0]  wsize;
        logic        aincr;
        logic [7:0]  wcount;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    bit   m_busy = 1'b0;
    int   m_idx  = 0;
    int   m_ptr  = 0;

    function automatic int winner(input logic [NR-1:0] v, input int start);
        int s;
        int k;
        s = start;
`ifdef MREQ_ARB_FIXED_PRIO_EN
        s = 0;
`endif
        for (int i = 0; i < NR; i++) begin
            k = (s + i) % NR;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (m_busy) begin
            if (!req_valid[m_idx]) begin
                void'(exp_q.pop_back());
                exp_err++;
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % NR;
            end else if (mreq_ready) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % NR;
            end
        end else if (req_valid != '0) begin
            m_idx    = winner(req_valid, m_ptr);
            m_busy   = 1'b1;
            e.idx    = m_idx;
            e.wr     = req_wr[m_idx];
            e.wsize  = req_wsize[2*m_idx +: 2];
            e.aincr  = req_aincr[m_idx];
            e.wcount = req_wcount[8*m_idx +: 8];
            e.addr   = req_addr[32*m_idx +: 32];
            exp_q.push_back(e);
        end
    end

    // Monitor: compare every completion against the oldest predicted grant.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (err_proto) err_seen++;
            if (req_ready != '0) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_ready", 64'(req_ready), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_ready_onehot", 64'(req_ready), 64'(1) << e.idx);
                    check("sb_grant", 64'(grant), 64'(1) << e.idx);
                    check("sb_grant_idx", 64'(grant_idx), 64'(e.idx));
                    check("sb_mreq_valid", 64'(mreq_valid), 64'(1));
                    check("sb_addr", 64'(mreq_addr), 64'(e.addr));
                    check("sb_wcount", 64'(mreq_wcount), 64'(e.wcount));
                    check("sb_ctrl", 64'({mreq_wr, mreq_wsize, mreq_aincr}),
                          64'({e.wr, e.wsize, e.aincr}));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields(input int k);
        req_wr[k]              = 1'($urandom_range(0, 1));
        req_wsize[2*k +: 2]    = 2'($urandom_range(0, 2));
        req_aincr[k]           = 1'($urandom_range(0, 1));
        req_wcount[8*k +: 8]   = 8'($urandom);
        req_addr[32*k +: 32]   = $urandom;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},      64'(busy), 64'(0));
        check({tag, "_grant"},     64'(grant), 64'(0));
        check({tag, "_grant_idx"}, 64'(grant_idx), 64'(0));
        check({tag, "_mvalid"},    64'(mreq_valid), 64'(0));
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_err"},       64'(err_proto), 64'(0));
    endtask

    int exp_seq[4];
    logic [NR-1:0] rdy_snap;

    initial begin
`ifdef MREQ_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{1, 0, 1, 0};
`endif
        // ---------------- reset ----------------
        repeat (3) cyc();
        @(negedge clk);
        check_reset_values("rst");
        cyc(); rst_n = 1'b1;
        cyc();

        // ---------------- single request, latency, late ready ----------------
        req_wr[0] = 1'b1; req_wsize[1:0] = 2'd2; req_aincr[0] = 1'b1;
        req_wcount[7:0] = 8'd4; req_addr[31:0] = 32'h0000_1000;
        req_valid = 3'b001;
        @(negedge clk);
        check("t1_latency_not_yet", 64'(mreq_valid), 64'(0));
        cyc();
        @(negedge clk);
        check("t1_mvalid", 64'(mreq_valid), 64'(1));
        check("t1_grant", 64'(grant), 64'(3'b001));
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_addr", 64'(mreq_addr), 64'(32'h1000));
        check("t1_wcount", 64'(mreq_wcount), 64'(4));
        check("t1_wr", 64'(mreq_wr), 64'(1));
        repeat (4) begin
            cyc();
            @(negedge clk);
            check("t1_no_ready_yet", 64'(req_ready), 64'(0));
        end
        cyc(); mreq_ready = 1'b1;
        @(negedge clk);
        check("t1_ready_pulse", 64'(req_ready), 64'(3'b001));
        cyc(); mreq_ready = 1'b0; req_valid = '0;
        @(negedge clk);
        check("t1_idle_after", 64'(busy), 64'(0));
        check("t1_ready_gone", 64'(req_ready), 64'(0));

        // ---------------- two continuous requesters ----------------
        cyc();
        rand_fields(0); rand_fields(1);
        req_valid = 3'b011;
        cyc();
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            check("t2_busy", 64'(busy), 64'(1));
            check("t2_grant_idx", 64'(grant_idx), 64'(exp_seq[g]));
            cyc(); cyc(); mreq_ready = 1'b1;
            @(negedge clk);
            check("t2_ready", 64'(req_ready), 64'(1) << exp_seq[g]);
            cyc(); mreq_ready = 1'b0;
            rand_fields(exp_seq[g]);
            if (g == 3) req_valid = '0;
            @(negedge clk);
            check("t2_bubble", 64'(busy), 64'(0));
            cyc();
        end

        // ---------------- late arrival waits ----------------
        req_wr[0] = 1'b0; req_addr[31:0] = 32'hA000_0000; req_valid = 3'b001;
        cyc();
        req_wr[1] = 1'b1; req_addr[63:32] = 32'hB000_0004; req_valid[1] = 1'b1;
        @(negedge clk);
        check("t3_idx0", 64'(grant_idx), 64'(0));
        check("t3_addr_a", 64'(mreq_addr), 64'(32'hA000_0000));
        check("t3_r1_waits", 64'(req_ready), 64'(0));
        cyc(); mreq_ready = 1'b1;
        @(negedge clk);
        check("t3_ready0", 64'(req_ready), 64'(3'b001));
        cyc(); mreq_ready = 1'b0; req_valid[0] = 1'b0;
        @(negedge clk);
        check("t3_bubble", 64'(busy), 64'(0));
        cyc();
        @(negedge clk);
        check("t3_idx1", 64'(grant_idx), 64'(1));
        check("t3_grant1", 64'(grant), 64'(3'b010));
        check("t3_addr_b", 64'(mreq_addr), 64'(32'hB000_0004));
        cyc(); mreq_ready = 1'b1;
        @(negedge clk);
        check("t3_ready1", 64'(req_ready), 64'(3'b010));
        cyc(); mreq_ready = 1'b0; req_valid = '0;

        // ---------------- abort ----------------
        cyc();
        rand_fields(0); req_valid = 3'b001;
        cyc();
        rand_fields(1); req_valid[1] = 1'b1;
        @(negedge clk);
        check("t4_idx0", 64'(grant_idx), 64'(0));
        cyc(); req_valid[0] = 1'b0;
        @(negedge clk);
        check("t4_err_pulse", 64'(err_proto), 64'(1));
        check("t4_mvalid_low", 64'(mreq_valid), 64'(0));
        check("t4_no_ready", 64'(req_ready), 64'(0));
        cyc();
        @(negedge clk);
        check("t4_idle", 64'(busy), 64'(0));
        check("t4_err_once", 64'(err_proto), 64'(0));
        cyc();
        @(negedge clk);
        check("t4_busy1", 64'(busy), 64'(1));
        check("t4_idx1", 64'(grant_idx), 64'(1));
        cyc(); mreq_ready = 1'b1;
        cyc(); mreq_ready = 1'b0; req_valid = '0;

        // ---------------- ready in idle, then reset mid-transaction ----------
        cyc(); mreq_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t5_idle_ready_ignored", 64'(req_ready), 64'(0));
            cyc();
        end
        mreq_ready = 1'b0;
        rand_fields(2); req_valid = 3'b100;
        cyc();
        @(negedge clk);
        check("t5_busy", 64'(busy), 64'(1));
        check("t5_idx2", 64'(grant_idx), 64'(2));
        cyc(); rst_n = 1'b0;
        @(negedge clk);
        check("t5_sync_reset_not_yet", 64'(busy), 64'(1));
        cyc();
        @(negedge clk);
        check_reset_values("t5_rst");
        cyc();
        @(negedge clk);
        check("t5_held_in_reset", 64'(busy), 64'(0));
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        check("t5_release_edge", 64'(busy), 64'(0));
        cyc();
        @(negedge clk);
        check("t5_regrant_busy", 64'(busy), 64'(1));
        check("t5_regrant_idx", 64'(grant_idx), 64'(2));
        cyc(); mreq_ready = 1'b1;
        cyc(); mreq_ready = 1'b0; req_valid = '0;

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rdy_snap = req_ready;
            cyc();
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k] && rdy_snap[k]) begin
                    req_valid[k] = 1'b0;
                end else if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
                    rand_fields(k);
                    req_valid[k] = 1'b1;
                end else if (req_valid[k] && $urandom_range(0, 63) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            mreq_ready = 1'($urandom_range(0, 1));
        end

        // Drain: no new requests, execution side always ready.
        for (int c = 0; c < 200 && req_valid != '0; c++) begin
            @(negedge clk);
            rdy_snap = req_ready;
            cyc();
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k] && rdy_snap[k]) req_valid[k] = 1'b0;
            end
            mreq_ready = 1'b1;
        end
        check("drain_done", 64'(req_valid), 64'(0));
        cyc(); mreq_ready = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("sb_queue_empty", 64'(exp_q.size()), 64'(0));
        check("err_pulse_count", 64'(err_seen), 64'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mreq_arb
